// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a 2-entry skid buffer.
// Latency: 1 cycle from an accepted input beat to out_valid; sustains 1 beat/cycle while out_ready=1.
// Backpressure: in_ready is the inverted skid-valid flop; out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   flush                  synchronous kill of every held beat (beat offered that cycle is dropped)
//   in_valid/in_ready      upstream handshake; in_data (DATA_W), in_ctrl (CTRL_W)
//   out_valid/out_ready    downstream handshake; out_data, out_ctrl (out_ctrl is zero whenever out_valid=0)
//   stall_cnt, flush_cnt   saturating perf counters, present only with PIPE_STAGE_PERF_EN defined
//
// Optional feature macro: PIPE_STAGE_PERF_EN (adds CNT_W parameter and the two counter ports).
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  // Encoding is {skid_valid, main_valid}, so both valid bits are state flops
  // and in_ready / out_valid come straight from a register bit.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] m_data, s_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl;

  logic ld_m_in;    // main entry takes the upstream beat
  logic ld_m_skid;  // main entry takes the skid entry
  logic ld_s;       // skid entry takes the upstream beat

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and entry-load decode. Flush overrides every transfer; a
  // downstream handshake in the flush cycle has already happened on the wires.
  always_comb begin
    state_d   = state_q;
    ld_m_in   = 1'b0;
    ld_m_skid = 1'b0;
    ld_s      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            ld_m_in = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            ld_m_in = 1'b1;
          end else if (in_valid) begin
            ld_s    = 1'b1;
            state_d = ST_FULL;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            ld_m_skid = 1'b1;
            state_d   = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Entry storage. Payload is not cleared on flush; the valid bits gate it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data <= '0;
      m_ctrl <= '0;
      s_data <= '0;
      s_ctrl <= '0;
    end else begin
      if (ld_m_in) begin
        m_data <= in_data;
        m_ctrl <= in_ctrl;
      end else if (ld_m_skid) begin
        m_data <= s_data;
        m_ctrl <= s_ctrl;
      end
      if (ld_s) begin
        s_data <= in_data;
        s_ctrl <= in_ctrl;
      end
    end
  end

  // Outputs. An empty main entry presents an all-zero control bundle so the
  // next stage sees a NOP bubble regardless of stale payload.
  always_comb begin
    out_valid = state_q[0];
    in_ready  = ~state_q[1];
    out_data  = m_data;
    out_ctrl  = state_q[0] ? m_ctrl : '0;
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters, cleared only by reset. The skid entry can only be
  // valid when the main entry is, so "any beat held" is simply main valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state_q[0] && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && state_q[0] && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg.
// Accepted beats are queued; the monitor compares the DUT against the queue every cycle.
// Directed reset/stream/backpressure/flush/bubble phases, then randomized traffic.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt;
  logic [15:0]   flush_cnt;
`endif

  pipe_stage_reg #(
    .DATA_W(DW),
    .CTRL_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t sb_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  logic [15:0] exp_stall = '0;
  logic [15:0] exp_flush = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus-side logger: records each beat the DUT accepts (dropped if flushed).
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && in_valid && in_ready && !flush) begin
        b.d = in_data;
        b.c = in_ctrl;
        sb_q.push_back(b);
      end
    end
  end

  // Monitor: the model is just an ordered queue of up to two held beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_stall = '0;
      exp_flush = '0;
    end else begin
      check("out_valid", out_valid, sb_q.size() > 0);
      check("in_ready", in_ready, sb_q.size() < 2);
      if (sb_q.size() > 0) begin
        check("out_data", out_data, sb_q[0].d);
        check("out_ctrl", out_ctrl, sb_q[0].c);
      end else begin
        check("bubble_ctrl", out_ctrl, '0);
      end
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", stall_cnt, exp_stall);
      check("flush_cnt", flush_cnt, exp_flush);
      if (sb_q.size() > 0 && !out_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      if (flush && sb_q.size() > 0 && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
`endif
      if (sb_q.size() > 0 && out_ready) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, ordy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_ctrl"}, out_ctrl, '0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [DW-1:0] d;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    #3;
    check_reset_outputs("init");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2, 1'b1);

    // Streaming 1..4 with out_ready=1: monitor expects back-to-back delivery.
    for (int i = 1; i <= 4; i++) drive(1'b1, DW'(i), CW'(16'h0100 + i), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Backpressure: A, B into a stalled stage, then drain over two cycles.
    drive(1'b1, DW'(128'hA), 16'h00A1, 1'b0, 1'b0);
    drive(1'b1, DW'(128'hB), 16'h00B2, 1'b0, 1'b0);
    drive(1'b1, DW'(128'hD), 16'h00D4, 1'b0, 1'b0);  // refused: stage full
    idle(2, 1'b0);
    #2;
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_hold_A", out_data, DW'(128'hA));
    idle(2, 1'b1);
    idle(2, 1'b1);

    // Flush while full, with C offered in the flush cycle.
    drive(1'b1, DW'(128'hA), 16'h00A1, 1'b0, 1'b0);
    drive(1'b1, DW'(128'hB), 16'h00B2, 1'b0, 1'b0);
    idle(1, 1'b0);
    drive(1'b1, DW'(128'hC), 16'h00C3, 1'b0, 1'b1);
    idle(1, 1'b1);
    #2;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_ctrl", out_ctrl, '0);
    check("flush_in_ready", in_ready, 1'b1);
    idle(2, 1'b1);

    // Flush coinciding with a downstream handshake in ONE state.
    drive(1'b1, DW'(128'h11), 16'h0011, 1'b0, 1'b0);
    drive(1'b1, DW'(128'h22), 16'h0022, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Bubble: control pattern without valid never reaches out_ctrl.
    drive(1'b0, DW'(128'h55), 16'hFFFF, 1'b1, 1'b0);
    drive(1'b0, DW'(128'h55), 16'hFFFF, 1'b0, 1'b0);
    #2;
    check("bubble_direct", out_ctrl, '0);
    idle(1, 1'b1);

    // Reset in the middle of a held transfer.
    drive(1'b1, DW'(128'hF0), 16'h00F0, 1'b0, 1'b0);
    drive(1'b1, DW'(128'hF1), 16'h00F1, 1'b0, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      d = rand_data();
      drive(($urandom % 4) != 0, d, CW'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
    end
    idle(4, 1'b1);

`ifdef PIPE_STAGE_PERF_EN
    // Five stall cycles, then a flush of the held beat; then a flush while empty.
    do_reset();
    drive(1'b1, DW'(128'h77), 16'h0077, 1'b0, 1'b0);
    idle(5, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    #2;
    check("perf_stall5", stall_cnt, 16'd5);
    check("perf_flush1", flush_cnt, 16'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    #2;
    check("perf_flush_empty", flush_cnt, 16'd1);
    idle(2, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic parametrised pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB), replacing per-stage hand-written register modules.
- Carries a DATA_W data bundle and a CTRL_W control bundle, using a valid/ready handshake and a 2-entry skid buffer.
- Sustains full throughput while keeping the in_ready path registered.
- Synchronous flush kills in-flight beats. Invalid slots present all-zero control (NOP bubble).

Parameters:
DATA_W, 128, width of data bundle (pc, pc+4, imm, operands, reg addresses)
CTRL_W, 16, width of control bundle (we_rf, we_dm, sel_result, alu_control, ...)
CNT_W, 16, width of performance counters (used only with PIPE_STAGE_PERF_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held beats
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept beat
in_data  in  DATA_W  upstream data bundle
in_ctrl  in  CTRL_W  upstream control bundle
out_valid  out  1  downstream beat valid
out_ready  in  1  downstream accepts beat
out_data  out  DATA_W  data bundle to next stage
out_ctrl  out  CTRL_W  control bundle to next stage; zero when out_valid=0
stall_cnt  out  CNT_W  [PIPE_STAGE_PERF_EN only] backpressure cycles
flush_cnt  out  CNT_W  [PIPE_STAGE_PERF_EN only] flushes that killed ≥1 valid beat

Behaviour:
- Reset (rst_n=0, async, immediate): main/skid entries invalid, all data/ctrl registers 0.
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=1. Counters 0.
  - Reset mid-transfer discards everything.
- Transfer rules: upstream transfer when in_valid&in_ready; downstream transfer when out_valid&out_ready.
- Storage: main entry M drives outputs; skid entry S.
  - in_ready = ~S.valid, taken directly from a flop; no combinational path from out_ready.
- State machine, evaluated each rising edge, no flush:
  - EMPTY (M invalid): in_valid -> M<=in, go ONE.
  - ONE (M valid, S invalid):
    - in_valid&out_ready -> M<=in, stay ONE.
    - in_valid&~out_ready -> S<=in, go FULL.
    - ~in_valid&out_ready -> go EMPTY.
    - Otherwise hold.
  - FULL (both valid, in_ready=0):
    - out_ready -> M<=S, S invalid, go ONE.
    - Otherwise hold.
- Latency: 1 cycle from upstream transfer into EMPTY to out_valid=1. Throughput: 1 beat/cycle in ONE with out_ready=1.
- Ordering strictly FIFO. No beat is duplicated or dropped except by flush.
- Stability: while out_valid&~out_ready, out_data/out_ctrl are held unchanged.
- Bubble: whenever out_valid=0, out_ctrl=0. out_data holds its last value, don't-care.
- flush=1 at an edge:
  - Highest priority over all transfers: next state EMPTY, out_ctrl=0, in_ready=1.
  - A beat presented that cycle is dropped.
  - An out_ready handshake in the flush cycle still counts as delivered downstream.
- Simultaneous flush and rst_n=0: reset wins.
- No arithmetic on bundles; widths pass through unchanged.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments on each cycle with out_valid&~out_ready.
  - flush_cnt increments on each flush edge where M or S was valid.
  - Both saturate at all-ones. Both are cleared only by reset.
- Undefined: counter ports and logic are absent; core behaviour is identical.

Test Plan:
- Reset: rst_n low mid-cycle with a beat held -> immediately out_valid=0, out_ctrl=0, in_ready=1, out_data=0.
- Streaming: out_ready=1; in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 on the following consecutive cycles, latency 1, no gaps.
- Backpressure:
  - Send A, B with out_ready=0 -> FULL, in_ready=0, out_data=A held.
  - Raise out_ready for 2 cycles -> A then B delivered, in_ready=1 after the first.
- Flush: FULL with A, B; assert flush with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, C never appears.
- Bubble: in_ctrl=16'hFFFF with in_valid=0 -> out_ctrl stays 0.
- Perf (PIPE_STAGE_PERF_EN): 5 stall cycles then a flush of a held beat -> stall_cnt=5, flush_cnt=1. Flush while EMPTY -> flush_cnt unchanged.
